// File: rtl/duart_pkg.sv
// rtl/duart_pkg.sv - shared DUART types, mode codes and character helpers
package duart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  localparam logic [1:0] PAR_WITH  = 2'b00;
  localparam logic [1:0] PAR_FORCE = 2'b01;
  localparam logic [1:0] PAR_NONE  = 2'b10;

  // Mask of the data bits that belong to a character of the selected length
  function automatic logic [7:0] char_mask(input logic [1:0] bits_sel);
    case (bits_sel)
      BITS_5:  char_mask = 8'h1F;
      BITS_6:  char_mask = 8'h3F;
      BITS_7:  char_mask = 8'h7F;
      default: char_mask = 8'hFF;
    endcase
  endfunction

  // Parity bit for a character; par_type selects odd/even, or is the bit itself when forced
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] bits_sel,
                                       input logic [1:0] par_mode, input logic par_type);
    if (par_mode == PAR_FORCE) calc_parity = par_type;
    else                       calc_parity = (^(data & char_mask(bits_sel))) ^ par_type;
  endfunction

endpackage

// File: rtl/duart_bit_timer.sv
// rtl/duart_bit_timer.sv - counts DIV baud ticks per serial bit and flags the last one
module duart_bit_timer #(
  parameter int DIV = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_restart,
  output logic o_bit_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // A restart wins over a tick so a freshly started bit always gets its full DIV ticks
  assign o_bit_done = i_tick & ~i_restart & (r_cnt == LAST);

  // Tick counter, wraps to zero on the tick that ends the bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           r_cnt <= '0;
    else if (i_restart)  r_cnt <= '0;
    else if (i_tick)     r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/duart_tx_channel.sv
// rtl/duart_tx_channel.sv - one DUART transmit channel: 1-deep THR plus serialiser
module duart_tx_channel
  import duart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr,
  input  logic [7:0] i_d_in,
  input  logic       i_tx_en,
  input  logic       i_baud_tick,
  input  logic [1:0] i_bits_sel,
  input  logic [1:0] i_par_mode,
  input  logic       i_par_type,
  input  logic       i_stop2,
  input  logic       i_send_break,
  output logic       o_txd,
  output logic       o_tx_rdy,
  output logic       o_tx_emt
);

  tx_state_t  r_state, w_state_next;
  logic [7:0] r_thr, r_shift;
  logic       r_thr_full;
  logic [2:0] r_bit_cnt;
  logic [1:0] r_bits;
  logic       r_par_en, r_par_bit, r_stop2;
  logic       r_txd, r_tx_rdy, r_tx_emt;

  logic w_bit_done, w_restart, w_load, w_wr_ok, w_thr_full_next, w_txd_next;
  logic w_last_data, w_stop_done;

  duart_bit_timer #(.DIV(DIV)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tick     (i_baud_tick),
    .i_restart  (w_restart),
    .o_bit_done (w_bit_done)
  );

  // Last data bit index is char length - 1, i.e. bits code + 4
  assign w_last_data = (r_bit_cnt == ({1'b0, r_bits} + 3'd4));
  assign w_stop_done = ~r_stop2 | r_bit_cnt[0];

  // Writes only land when the registered ready says so; a load empties the THR
  assign w_wr_ok         = i_wr & r_tx_rdy;
  assign w_thr_full_next = w_load ? 1'b0 : (w_wr_ok | r_thr_full);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; a pending byte waits in IDLE while a break is requested
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_thr_full && !i_send_break) w_state_next = START;
      START:   if (w_bit_done) w_state_next = DATA;
      DATA:    if (w_bit_done && w_last_data) w_state_next = r_par_en ? PARITY : STOP;
      PARITY:  if (w_bit_done) w_state_next = STOP;
      STOP:    if (w_bit_done && w_stop_done) w_state_next = r_thr_full ? START : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: shifter load strobes and the next TXD level
  always_comb begin
    w_load     = 1'b0;
    w_restart  = 1'b0;
    w_txd_next = r_txd;
    case (r_state)
      IDLE: begin
        w_txd_next = ~(i_send_break & ~r_thr_full);
        if (r_thr_full && !i_send_break) begin
          w_load     = 1'b1;
          w_restart  = 1'b1;
          w_txd_next = 1'b0;
        end
      end
      START:  if (w_bit_done) w_txd_next = r_shift[0];
      DATA: begin
        if (w_bit_done) begin
          if (w_last_data) w_txd_next = r_par_en ? r_par_bit : 1'b1;
          else             w_txd_next = r_shift[1];
        end
      end
      PARITY: if (w_bit_done) w_txd_next = 1'b1;
      STOP: begin
        if (w_bit_done && w_stop_done) begin
          if (r_thr_full) begin
            // back-to-back: next start bit follows the stop bit with no gap
            w_load     = 1'b1;
            w_txd_next = 1'b0;
          end else begin
            w_txd_next = ~i_send_break;
          end
        end
      end
      default: w_txd_next = 1'b1;
    endcase
  end

  // THR, shifter, sampled character format and registered status
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_thr      <= 8'h00;
      r_thr_full <= 1'b0;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_bits     <= BITS_8;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_rdy   <= 1'b0;
      r_tx_emt   <= 1'b1;
    end else begin
      if (w_wr_ok) r_thr <= i_d_in;
      r_thr_full <= w_thr_full_next;
      r_txd      <= w_txd_next;
      r_tx_rdy   <= i_tx_en & ~w_thr_full_next;
      r_tx_emt   <= (w_state_next == IDLE) & ~w_thr_full_next;
      if (w_load) begin
        // format is frozen here so mode changes mid-character are harmless
        r_shift   <= r_thr;
        r_bits    <= i_bits_sel;
        r_par_en  <= ~i_par_mode[1];
        r_par_bit <= calc_parity(r_thr, i_bits_sel, i_par_mode, i_par_type);
        r_stop2   <= i_stop2;
        r_bit_cnt <= 3'd0;
      end else if (w_bit_done) begin
        if (r_state == DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= w_last_data ? 3'd0 : r_bit_cnt + 3'd1;
        end else if (r_state == STOP) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end

  assign o_txd    = r_txd;
  assign o_tx_rdy = r_tx_rdy;
  assign o_tx_emt = r_tx_emt;

endmodule

// File: tb/tb_duart_tx_channel.sv
// tb/tb_duart_tx_channel.sv - scoreboard bench for duart_tx_channel
module tb_duart_tx_channel;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] bits;
    logic [1:0] pm;
    logic       pt;
    logic       s2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, wr, tx_en, tick, par_type, stop2, send_break;
  logic [7:0] d_in;
  logic [1:0] bits_sel, par_mode;
  logic       o_txd, o_tx_rdy, o_tx_emt;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  int   n_push = 0, frames_started = 0, frames_done = 0;
  int   last_start = 0, prev_start = 0, wr_cyc = 0;
  logic mon_en = 1'b1;

  duart_tx_channel #(.DIV(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr         (wr),
    .i_d_in       (d_in),
    .i_tx_en      (tx_en),
    .i_baud_tick  (tick),
    .i_bits_sel   (bits_sel),
    .i_par_mode   (par_mode),
    .i_par_type   (par_type),
    .i_stop2      (stop2),
    .i_send_break (send_break),
    .o_txd        (o_txd),
    .o_tx_rdy     (o_tx_rdy),
    .o_tx_emt     (o_tx_emt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; pulses wr for one cycle and returns at the next negedge
  task automatic send(input logic [7:0] d, input bit expect_ok);
    wr   = 1'b1;
    d_in = d;
    if (expect_ok) begin
      sb.push_back('{d, bits_sel, par_mode, par_type, stop2});
      n_push++;
    end
    @(negedge clk);
    wr     = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_done < n && k < 4000) begin @(negedge clk); k++; end
    if (frames_done < n) check("frame_timeout", frames_done, n);
  endtask

  task automatic wait_start(input int n);
    int k = 0;
    while (frames_started < n && k < 400) begin @(negedge clk); k++; end
    if (frames_started < n) check("start_timeout", frames_started, n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!o_tx_emt && k < 4000) begin @(negedge clk); k++; end
    if (!o_tx_emt) check("idle_timeout", o_tx_emt, 1);
    repeat (3) @(negedge clk);
  endtask

  // Receives one character starting at a detected falling edge, sampling mid-bit
  task automatic rx_frame();
    exp_t       e;
    logic [7:0] got, mask;
    logic       pexp;
    int         nb;
    prev_start = last_start;
    last_start = cyc;
    frames_started++;
    if (sb.size() == 0) begin
      check("frame_unexpected", 1, 0);
      e = '{8'h00, 2'b11, 2'b10, 1'b0, 1'b0};
    end else begin
      e = sb.pop_front();
    end
    nb   = 5 + int'(e.bits);
    mask = 8'hFF >> (8 - nb);
    got  = 8'h00;
    repeat (8) @(negedge clk);
    check("start_bit", o_txd, 0);
    for (int i = 0; i < nb; i++) begin
      repeat (16) @(negedge clk);
      got[i] = o_txd;
    end
    check("data", got, e.d & mask);
    if (!e.pm[1]) begin
      pexp = (e.pm == 2'b01) ? e.pt : ((^(e.d & mask)) ^ e.pt);
      repeat (16) @(negedge clk);
      check("parity", o_txd, pexp);
    end
    for (int i = 0; i < 1 + int'(e.s2); i++) begin
      repeat (16) @(negedge clk);
      check("stop_bit", o_txd, 1);
    end
    frames_done++;
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !o_txd) begin
        rx_frame();
        prev = 1'b1;
      end else begin
        prev = o_txd;
      end
    end
  end

  initial begin : stim
    int   k, s;
    logic seen_emt;
    rst = 1'b1; wr = 1'b0; d_in = 8'h00; tx_en = 1'b1; tick = 1'b1;
    bits_sel = 2'b11; par_mode = 2'b10; par_type = 1'b0; stop2 = 1'b0; send_break = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", o_txd, 1);
    check("rst_rdy", o_tx_rdy, 0);
    check("rst_emt", o_tx_emt, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", o_tx_rdy, 1);

    // 8N1 0x55: ready dips one clock, start one clock after the write, empty after 160 clk
    send(8'h55, 1);
    check("rdy_drop", o_tx_rdy, 0);
    @(negedge clk);
    check("rdy_back", o_tx_rdy, 1);
    wait_frames(n_push);
    check("load_latency", last_start - wr_cyc, 1);
    while (cyc < last_start + 159) @(negedge clk);
    check("emt_before_end", o_tx_emt, 0);
    @(negedge clk);
    check("emt_after_end", o_tx_emt, 1);
    wait_idle();

    // 7 bits, 2 stop: even, odd, forced-1 parity on 0x43
    for (int t = 0; t < 3; t++) begin
      bits_sel = 2'b10; stop2 = 1'b1;
      par_mode = (t == 2) ? 2'b01 : 2'b00;
      par_type = (t == 0) ? 1'b0 : 1'b1;
      send(8'h43, 1);
      wait_start(n_push);
      if (t == 0) begin
        bits_sel = 2'b11; par_mode = 2'b10; stop2 = 1'b0; par_type = 1'b1;
      end
      wait_frames(n_push);
      wait_idle();
    end

    // back-to-back 0xA5, 0x3C
    bits_sel = 2'b11; par_mode = 2'b10; par_type = 1'b0; stop2 = 1'b0;
    send(8'hA5, 1);
    k = 0;
    while (!o_tx_rdy && k < 100) begin @(negedge clk); k++; end
    send(8'h3C, 1);
    seen_emt = 1'b0;
    k = 0;
    while (frames_done < n_push && k < 4000) begin
      @(negedge clk);
      seen_emt = seen_emt | o_tx_emt;
      k++;
    end
    wait_frames(n_push);
    check("b2b_emt_low", seen_emt, 0);
    check("b2b_gap", last_start - prev_start, 160);
    wait_idle();

    // second write lands on the transfer cycle while ready is low
    send(8'h11, 1);
    check("rdy_low_full", o_tx_rdy, 0);
    send(8'h22, 0);
    wait_frames(n_push);
    wait_idle();
    repeat (50) @(negedge clk);
    check("no_extra_frame", frames_started, n_push);

    // transmitter disabled: ready drops and writes are ignored
    tx_en = 1'b0;
    @(negedge clk);
    check("rdy_txen_off", o_tx_rdy, 0);
    send(8'h77, 0);
    repeat (5) @(negedge clk);
    check("txen_write_ignored", o_tx_emt, 1);
    tx_en = 1'b1;
    @(negedge clk);
    check("rdy_txen_on", o_tx_rdy, 1);

    // reset 40 clocks into a character of zeros
    mon_en = 1'b0;
    send(8'h00, 0);
    k = 0;
    while (o_txd && k < 100) begin @(negedge clk); k++; end
    s = cyc;
    while (cyc < s + 40) @(negedge clk);
    check("mid_char_low", o_txd, 0);
    rst = 1'b1;
    #1;
    check("abort_txd", o_txd, 1);
    check("abort_emt", o_tx_emt, 1);
    check("abort_rdy", o_tx_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_abort", o_tx_rdy, 1);
    mon_en = 1'b1;
    send(8'h96, 1);
    wait_frames(n_push);
    wait_idle();

    // break in idle, then break requested during 0xFF
    mon_en = 1'b0;
    send_break = 1'b1;
    repeat (2) @(negedge clk);
    check("break_idle", o_txd, 0);
    send_break = 1'b0;
    repeat (2) @(negedge clk);
    check("break_release", o_txd, 1);
    mon_en = 1'b1;
    send(8'hFF, 1);
    wait_start(n_push);
    mon_en = 1'b0;
    send_break = 1'b1;
    k = 0;
    while (cyc < last_start + 159 && k < 400) begin @(negedge clk); k++; end
    check("brk_stop_high", o_txd, 1);
    @(negedge clk);
    check("brk_after_char", o_txd, 0);
    wait_frames(n_push);
    send(8'h5A, 1);
    repeat (20) @(negedge clk);
    check("held_in_thr", o_tx_emt, 0);
    check("held_no_start", frames_started, n_push - 1);
    mon_en = 1'b1;
    send_break = 1'b0;
    wait_frames(n_push);
    wait_idle();

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("frames_total", frames_done, n_push);
    check("idle_txd", o_txd, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
